cnn_stream_classifier: RTL and testbench

Parametrised, sequential successor to the fixed 16x16 binary CNN classifier. It accepts a square binary image as a serial pixel stream and applies NUM_K 3x3 binary kernels (valid convolution). Each feature map is zero-padded by one ring and reduced by 2x2 max-pooling; pooled values are summed into a score and compared against a threshold. It sits between the image binariser and the detection result register, and exchanges data through valid/ready handshakes on both sides.

---
 rtl/cnn_stream_classifier_pkg.sv | 27 ++
 rtl/cnn_stream_classifier_if.sv | 32 +++
 rtl/cnn_stream_classifier_conv3x3.sv | 15 +
 rtl/cnn_stream_classifier.sv | 166 ++++++++++++++++
 tb/tb_cnn_stream_classifier.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_stream_classifier_pkg.sv
// cnn_pkg: shared definitions for the streaming binary CNN classifier.
//   score_width() - bits needed to hold the largest possible pooled score
//   state_t       - LOAD / COMPUTE / OUT control states
//   popcount9()   - number of set bits in a 9-bit vector (0..9)
package cnn_pkg;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        OUT
    } state_t;

    // Every pooled cell of every kernel contributes at most 9.
    function automatic int score_width(input int img_w, input int num_k);
        return $clog2(num_k * (img_w / 2) * (img_w / 2) * 9 + 1);
    endfunction

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/cnn_stream_classifier_if.sv
// cnn_stream_classifier_if: pixel-in / result-out handshake bundle.
//   in_pixel, in_valid, in_ready : serial pixel stream, row-major
//   out_valid, out_ready         : result handshake
//   result, score                : classification bit and pooled sum
// master = pixel producer / result consumer, slave = classifier.
interface cnn_stream_classifier_if #(
    parameter int IMG_W = 16,
    parameter int NUM_K = 2
);
    import cnn_pkg::*;

    localparam int SCORE_W = score_width(IMG_W, NUM_K);

    logic               in_pixel;
    logic               in_valid;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic               result;
    logic [SCORE_W-1:0] score;

    modport master (
        output in_pixel, in_valid, out_ready,
        input  in_ready, out_valid, result, score
    );

    modport slave (
        input  in_pixel, in_valid, out_ready,
        output in_ready, out_valid, result, score
    );

endinterface

// File: rtl/cnn_stream_classifier_conv3x3.sv
// cnn_conv3x3: one 3x3 binary convolution tap set.
//   window : 9 image bits, bit 3*r+c = pixel (r,c) of the window
//   kernel : 9 weight bits, same layout
//   count  : popcount(window & kernel), 0..9
module cnn_conv3x3
    import cnn_pkg::*;
(
    input  logic [8:0] window,
    input  logic [8:0] kernel,
    output logic [3:0] count
);

    assign count = popcount9(window & kernel);

endmodule

// File: rtl/cnn_stream_classifier.sv
// cnn_stream_classifier: loads an IMG_W x IMG_W binary frame from a pixel
// stream, then walks the 2x2 pooling grid one cell per cycle, summing the
// max-pooled, zero-padded convolution outputs of NUM_K kernels into a score.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of cnn_stream_classifier_if (pixel stream in,
//              result/score out, valid/ready on both sides)
module cnn_stream_classifier
    import cnn_pkg::*;
#(
    parameter int               IMG_W   = 16,
    parameter int               NUM_K   = 2,
    parameter logic [NUM_K*9-1:0] KERNELS = {NUM_K{9'h1FF}},
    parameter int               THRESH  = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    cnn_stream_classifier_if.slave  bus
);

    localparam int SCORE_W = score_width(IMG_W, NUM_K);
    localparam int NPIX    = IMG_W * IMG_W;
    localparam int PIX_W   = $clog2(NPIX);
    localparam int HALF    = IMG_W / 2;
    localparam int PW      = $clog2(HALF);

    state_t             state;
    logic [NPIX-1:0]    fb;
    logic [PIX_W-1:0]   pix_cnt;
    logic [PW-1:0]      pi;
    logic [PW-1:0]      pj;
    logic               fin;
    logic [SCORE_W-1:0] acc;
    logic [SCORE_W-1:0] cell_sum;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               result_q;
    logic [SCORE_W-1:0] score_q;
    logic [3:0][8:0]    win;
    logic [3:0]         cnt [NUM_K][4];
    logic [3:0]         best;
    int                 r;
    int                 c;
    logic               accept;

    assign accept        = bus.in_valid && in_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.score     = score_q;

    // Frame buffer is fully rewritten before every COMPUTE, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            fb[pix_cnt] <= bus.in_pixel;
        end
    end

    // Windows for the four padded positions of pooled cell (pi,pj).
    // Padded p(r,c) maps to feature f(r-1,c-1); the padding ring gets an
    // all-zero window so its popcount is 0 without a separate mux.
    always_comb begin
        win = '0;
        r   = 0;
        c   = 0;
        for (int unsigned p = 0; p < 4; p++) begin
            r = 2 * int'(pi) + int'(p / 2);
            c = 2 * int'(pj) + int'(p % 2);
            if (r >= 1 && r <= IMG_W - 2 && c >= 1 && c <= IMG_W - 2) begin
                for (int unsigned wr = 0; wr < 3; wr++) begin
                    for (int unsigned wc = 0; wc < 3; wc++) begin
                        win[p][3*wr+wc] = fb[(r - 1 + int'(wr)) * IMG_W + (c - 1 + int'(wc))];
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_K; k++) begin : g_kernel
        for (genvar p = 0; p < 4; p++) begin : g_pos
            cnn_conv3x3 u_conv (
                .window (win[p]),
                .kernel (KERNELS[k*9 +: 9]),
                .count  (cnt[k][p])
            );
        end
    end

    always_comb begin
        cell_sum = '0;
        best     = '0;
        for (int unsigned k = 0; k < NUM_K; k++) begin
            best = '0;
            for (int unsigned p = 0; p < 4; p++) begin
                if (cnt[k][p] > best) begin
                    best = cnt[k][p];
                end
            end
            cell_sum = cell_sum + SCORE_W'(best);
        end
    end

    // COMPUTE accumulates one cell per cycle; 'fin' marks the extra cycle
    // that publishes the finished sum to score/result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            pix_cnt     <= '0;
            pi          <= '0;
            pj          <= '0;
            fin         <= 1'b0;
            acc         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= 1'b0;
            score_q     <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        pix_cnt <= pix_cnt + 1'b1;
                        if (pix_cnt == PIX_W'(NPIX - 1)) begin
                            state      <= COMPUTE;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                COMPUTE: begin
                    if (fin) begin
                        score_q     <= acc;
                        result_q    <= (32'(acc) >= 32'(THRESH));
                        out_valid_q <= 1'b1;
                        state       <= OUT;
                    end else begin
                        acc <= acc + cell_sum;
                        if (pj == PW'(HALF - 1)) begin
                            pj <= '0;
                            if (pi == PW'(HALF - 1)) begin
                                fin <= 1'b1;
                            end else begin
                                pi <= pi + 1'b1;
                            end
                        end else begin
                            pj <= pj + 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= LOAD;
                        pix_cnt     <= '0;
                        acc         <= '0;
                        pi          <= '0;
                        pj          <= '0;
                        fin         <= 1'b0;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_stream_classifier.sv
// Bench for cnn_stream_classifier: four instances with different kernel
// sets / thresholds share one pixel stream. Expected scores come from a
// direct feature-map / pad / pool model and are queued per instance.
module tb_cnn_stream_classifier;

    logic clk = 1'b0;
    logic rst;
    logic pix;
    logic vld;
    logic ordy;

    always #5 clk = ~clk;

    localparam int         NK   [4]    = '{1, 2, 1, 2};
    localparam int         THR  [4]    = '{576, 100, 577, 5};
    localparam logic [8:0] KERN [4][2] = '{'{9'h1FF, 9'h000}, '{9'h1FF, 9'h1FF},
                                           '{9'h1FF, 9'h000}, '{9'h1FF, 9'h010}};

    cnn_stream_classifier_if #(.IMG_W(16), .NUM_K(1)) if_a ();
    cnn_stream_classifier_if #(.IMG_W(16), .NUM_K(2)) if_b ();
    cnn_stream_classifier_if #(.IMG_W(16), .NUM_K(1)) if_c ();
    cnn_stream_classifier_if #(.IMG_W(16), .NUM_K(2)) if_d ();

    cnn_stream_classifier #(.IMG_W(16), .NUM_K(1), .KERNELS(9'h1FF), .THRESH(576))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    cnn_stream_classifier dut_b (.clk(clk), .rst(rst), .bus(if_b));
    cnn_stream_classifier #(.IMG_W(16), .NUM_K(1), .KERNELS(9'h1FF), .THRESH(577))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));
    cnn_stream_classifier #(.IMG_W(16), .NUM_K(2), .KERNELS({9'h010, 9'h1FF}), .THRESH(5))
        dut_d (.clk(clk), .rst(rst), .bus(if_d));

    assign if_a.in_pixel = pix;  assign if_a.in_valid = vld;  assign if_a.out_ready = ordy;
    assign if_b.in_pixel = pix;  assign if_b.in_valid = vld;  assign if_b.out_ready = ordy;
    assign if_c.in_pixel = pix;  assign if_c.in_valid = vld;  assign if_c.out_ready = ordy;
    assign if_d.in_pixel = pix;  assign if_d.in_valid = vld;  assign if_d.out_ready = ordy;

    logic [3:0]  ov, ir, rs;
    logic [10:0] sc [4];

    assign ov = {if_d.out_valid, if_c.out_valid, if_b.out_valid, if_a.out_valid};
    assign ir = {if_d.in_ready, if_c.in_ready, if_b.in_ready, if_a.in_ready};
    assign rs = {if_d.result, if_c.result, if_b.result, if_a.result};
    assign sc[0] = {1'b0, if_a.score};
    assign sc[1] = if_b.score;
    assign sc[2] = {1'b0, if_c.score};
    assign sc[3] = if_d.score;

    int checks = 0;
    int errors = 0;
    int exp_q [4][$];

    function automatic int model_score(input logic [255:0] img, input int d);
        int f [14][14];
        int total;
        int best;
        int pv;
        int pr;
        int pc;
        logic [8:0] kv;
        total = 0;
        for (int k = 0; k < NK[d]; k++) begin
            kv = KERN[d][k];
            for (int rr = 0; rr < 14; rr++) begin
                for (int cc = 0; cc < 14; cc++) begin
                    f[rr][cc] = 0;
                    for (int wr = 0; wr < 3; wr++) begin
                        for (int wc = 0; wc < 3; wc++) begin
                            if (img[(rr + wr) * 16 + cc + wc] && kv[3 * wr + wc]) f[rr][cc]++;
                        end
                    end
                end
            end
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    best = 0;
                    for (int dr = 0; dr < 2; dr++) begin
                        for (int dc = 0; dc < 2; dc++) begin
                            pr = 2 * i + dr;
                            pc = 2 * j + dc;
                            pv = (pr >= 1 && pr <= 14 && pc >= 1 && pc <= 14) ? f[pr-1][pc-1] : 0;
                            if (pv > best) best = pv;
                        end
                    end
                    total += best;
                end
            end
        end
        return total;
    endfunction

    function automatic logic [255:0] rand_img();
        logic [255:0] img;
        for (int i = 0; i < 256; i++) img[i] = 1'($urandom_range(0, 1));
        return img;
    endfunction

    task automatic send_frame(input logic [255:0] img, input int nbeats,
                              input bit gaps, input bit push);
        int  n = 0;
        int  guard = 0;
        bit  take;
        while (n < nbeats && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                vld = 1'b0;
            end else begin
                vld = 1'b1;
                pix = img[n];
            end
            take = vld && ir[0];
            @(posedge clk);
            if (take) n++;
        end
        @(negedge clk);
        vld = 1'b0;
        checks++;
        if (n != nbeats) begin
            errors++;
            $display("FAIL send_beats: accepted %0d want %0d", n, nbeats);
        end
        if (push) begin
            for (int d = 0; d < 4; d++) exp_q[d].push_back(model_score(img, d));
        end
    endtask

    task automatic drain_frame(input string name);
        int w = 0;
        int e;
        while (ov[0] !== 1'b1 && w < 500) begin
            @(posedge clk);
            @(negedge clk);
            w++;
        end
        checks++;
        if (ov[0] !== 1'b1) begin
            errors++;
            $display("FAIL %s out_valid_timeout: got %b want 1", name, ov[0]);
        end
        for (int d = 0; d < 4; d++) begin
            e = (exp_q[d].size() > 0) ? exp_q[d].pop_front() : -1;
            checks++;
            if (sc[d] !== 11'(e)) begin
                errors++;
                $display("FAIL %s score[%0d]: got %0d want %0d", name, d, sc[d], e);
            end
            checks++;
            if (rs[d] !== 1'(e >= THR[d])) begin
                errors++;
                $display("FAIL %s result[%0d]: got %b want %b", name, d, rs[d], e >= THR[d]);
            end
        end
        ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy = 1'b0;
        checks++;
        if (ov !== 4'b0000 || ir !== 4'b1111) begin
            errors++;
            $display("FAIL %s after_handshake: out_valid=%b in_ready=%b want 0000/1111", name, ov, ir);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || rs[d] !== 1'b0 || sc[d] !== 11'd0) begin
                errors++;
                $display("FAIL reset_state[%0d]: ir=%b ov=%b res=%b score=%0d want 1 0 0 0",
                         d, ir[d], ov[d], rs[d], sc[d]);
            end
        end
    endtask

    task automatic test_all_zero();
        int lat = 0;
        send_frame('0, 256, 1'b0, 1'b1);
        while (ov[0] !== 1'b1 && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 65) begin
            errors++;
            $display("FAIL zero_latency: got %0d cycles want 65", lat);
        end
        drain_frame("all_zero");
    endtask

    task automatic test_all_ones();
        send_frame('1, 256, 1'b0, 1'b1);
        drain_frame("all_ones");
    endtask

    task automatic test_single_pixel();
        logic [255:0] img;
        img = '0;
        img[5 * 16 + 5] = 1'b1;
        send_frame(img, 256, 1'b0, 1'b1);
        drain_frame("pixel_5_5");
        img = '0;
        img[0] = 1'b1;
        send_frame(img, 256, 1'b0, 1'b1);
        drain_frame("pixel_0_0");
    endtask

    task automatic test_backpressure();
        int w = 0;
        send_frame(rand_img(), 256, 1'b0, 1'b1);
        while (ov[0] !== 1'b1 && w < 200) begin
            @(posedge clk);
            @(negedge clk);
            w++;
        end
        vld = 1'b1;
        pix = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (ov[d] !== 1'b1 || ir[d] !== 1'b0 || sc[d] !== 11'(exp_q[d][0]) ||
                    rs[d] !== 1'(exp_q[d][0] >= THR[d])) begin
                    errors++;
                    $display("FAIL hold[%0d] cyc %0d: ov=%b ir=%b score=%0d res=%b want 1 0 %0d %b",
                             d, cyc, ov[d], ir[d], sc[d], rs[d], exp_q[d][0], exp_q[d][0] >= THR[d]);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        vld = 1'b0;
        drain_frame("backpressure");
        send_frame(rand_img(), 256, 1'b0, 1'b1);
        drain_frame("after_backpressure");
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            send_frame(rand_img(), 256, 1'b0, 1'b1);
            drain_frame("back_to_back");
        end
    endtask

    task automatic test_reset_abort();
        int w = 0;
        // abort mid-LOAD
        send_frame(rand_img(), 100, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        send_frame('1, 256, 1'b1, 1'b1);
        drain_frame("abort_load_ones_gaps");
        // abort mid-COMPUTE
        send_frame('1, 256, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (70) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ov !== 4'b0000 || ir !== 4'b1111) begin
                errors++;
                $display("FAIL abort_compute_idle: ov=%b ir=%b want 0000/1111", ov, ir);
            end
        end
        send_frame(rand_img(), 256, 1'b1, 1'b1);
        drain_frame("abort_compute_random_gaps");
        // abort in OUT
        send_frame('1, 256, 1'b0, 1'b0);
        while (ov[0] !== 1'b1 && w < 200) begin
            @(posedge clk);
            @(negedge clk);
            w++;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (ov[d] !== 1'b0 || sc[d] !== 11'd0 || rs[d] !== 1'b0 || ir[d] !== 1'b1) begin
                errors++;
                $display("FAIL abort_out[%0d]: ov=%b score=%0d res=%b ir=%b want 0 0 0 1",
                         d, ov[d], sc[d], rs[d], ir[d]);
            end
        end
        send_frame('1, 256, 1'b0, 1'b1);
        drain_frame("abort_out_ones");
    endtask

    initial begin
        rst  = 1'b1;
        pix  = 1'b0;
        vld  = 1'b0;
        ordy = 1'b0;
        test_reset();
        test_all_zero();
        test_all_ones();
        test_single_pixel();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
